// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and defaults for the instruction-fetch unit.
package ifu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OUT, S_DROP} state_e;
endpackage

// File: rtl/ifu_pc_fetch_pc_reg.sv
// pc_reg: program counter with load-enable; a redirect overrides the load.
module pc_reg import ifu_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load_i,
    input  logic            redir_i,
    input  logic [XLEN-1:0] npc_i,
    input  logic [XLEN-1:0] redir_pc_i,
    output logic [XLEN-1:0] pc_o
);
    logic [XLEN-1:0] pc_q, pc_d;
    assign pc_d = redir_i ? redir_pc_i : load_i ? npc_i : pc_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pc_q <= RESET_PC;
        else pc_q <= pc_d;
    end
    assign pc_o = pc_q;
endmodule

// File: rtl/ifu_pc_fetch.sv
// ifu_pc_fetch: PC register and single-outstanding fetch sequencer to decode.
// Optional misaligned-PC trap compiled in with IFU_MISALIGN_CHK_EN.
module ifu_pc_fetch import ifu_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] npc_in,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] pc_out,
    output logic            inst_exc,
    output logic [XLEN-1:0] fetch_cnt
);
    state_e state_q, state_d;
    logic [XLEN-1:0] inst_q, inst_d, cnt_q, cnt_d, pc;
    logic mis_pc, acc, deliver;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk       (clk),
        .rstn      (rstn),
        .load_i    (deliver),
        .redir_i   (redirect_valid),
        .npc_i     (npc_in),
        .redir_pc_i(redirect_pc),
        .pc_o      (pc)
    );

`ifdef IFU_MISALIGN_CHK_EN
    logic exc_q;
    assign mis_pc = |pc[1:0];
    // set when a misaligned PC short-circuits REQ into OUT, held only while in OUT
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) exc_q <= 1'b0;
        else exc_q <= state_d == S_OUT && (state_q == S_OUT ? exc_q : state_q == S_REQ);
    end
    assign inst_exc = exc_q;
`else
    assign mis_pc = 1'b0;
    assign inst_exc = 1'b0;
`endif

    assign imem_req_valid = state_q == S_REQ && !mis_pc;
    assign acc = imem_req_valid && imem_req_ready;
    assign deliver = state_q == S_OUT && inst_ready && !redirect_valid;
    assign cnt_d = deliver ? cnt_q + 32'd1 : cnt_q;
    assign inst_d = (state_q == S_WAIT && imem_rsp_valid && !redirect_valid) ? imem_rsp_data :
                    (state_q == S_REQ && mis_pc && !redirect_valid) ? NOP_INST : inst_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  state_d = redirect_valid ? (acc ? S_DROP : S_REQ) : mis_pc ? S_OUT : acc ? S_WAIT : S_REQ;
            S_WAIT: state_d = imem_rsp_valid ? (redirect_valid ? S_REQ : S_OUT) : (redirect_valid ? S_DROP : S_WAIT);
            S_OUT:  state_d = (redirect_valid || inst_ready) ? S_REQ : S_OUT;
            S_DROP: state_d = imem_rsp_valid ? S_REQ : S_DROP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            inst_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
        end
    end

    assign inst_valid = state_q == S_OUT;
    assign inst_out = inst_q;
    assign imem_req_addr = pc;
    assign pc_out = pc;
    assign fetch_cnt = cnt_q;
endmodule

// File: tb/tb_ifu_pc_fetch.sv
// tb_ifu_pc_fetch: directed bench with a transaction-level fetch model checked every cycle.
module tb_ifu_pc_fetch;
    logic clk = 1'b0, rstn = 1'b1;
    logic [31:0] npc_in = 32'h0, redirect_pc = 32'h0, imem_rsp_data = 32'h0;
    logic redirect_valid = 1'b0, imem_req_ready = 1'b1, imem_rsp_valid = 1'b0, inst_ready = 1'b1;
    logic imem_req_valid, inst_valid, inst_exc;
    logic [31:0] imem_req_addr, inst_out, pc_out, fetch_cnt;

    always #5 clk = ~clk;

    ifu_pc_fetch dut (
        .clk(clk), .rstn(rstn), .npc_in(npc_in), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .pc_out(pc_out),
        .inst_exc(inst_exc), .fetch_cnt(fetch_cnt)
    );

    int total = 0, bad = 0;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endfunction

    // model: started, a request in flight, whether its data is unwanted, an instruction held for decode
    bit m_started, m_out, m_stale, m_have, m_exc;
    logic [31:0] m_pc, m_inst, m_cnt;

    function automatic void model_reset();
        m_started = 0; m_out = 0; m_stale = 0; m_have = 0; m_exc = 0;
        m_pc = 32'h0; m_inst = 32'h0; m_cnt = 32'h0;
    endfunction

    function automatic bit m_reqv();
        return m_started && !m_out && !m_have
`ifdef IFU_MISALIGN_CHK_EN
            && m_pc[1:0] == 2'b00
`endif
            ;
    endfunction

    function automatic void model_update();
        bit rv;
        rv = m_reqv();
        if (!rstn) return;
        if (!m_started) begin
            m_started = 1;
            if (redirect_valid) m_pc = redirect_pc;
        end else if (redirect_valid) begin
            m_pc = redirect_pc;
            if (m_have) m_have = 0;
            else if (rv && imem_req_ready) begin m_out = 1; m_stale = 1; end
            else if (m_out) begin
                if (imem_rsp_valid) m_out = 0;
                else m_stale = 1;
            end
        end else if (m_have) begin
            if (inst_ready) begin m_pc = npc_in; m_cnt = m_cnt + 1; m_have = 0; end
        end else if (rv) begin
            if (imem_req_ready) begin m_out = 1; m_stale = 0; end
        end else if (m_out) begin
            if (imem_rsp_valid) begin
                m_out = 0;
                if (!m_stale) begin m_have = 1; m_inst = imem_rsp_data; m_exc = 0; end
            end
        end
`ifdef IFU_MISALIGN_CHK_EN
        else if (m_pc[1:0] != 2'b00) begin m_have = 1; m_inst = 32'h13; m_exc = 1; end
`endif
    endfunction

    always @(negedge clk) begin
        chk("req_valid", imem_req_valid, m_reqv());
        chk("req_addr", imem_req_addr, m_pc);
        chk("pc_out", pc_out, m_pc);
        chk("inst_valid", inst_valid, m_have);
        chk("fetch_cnt", fetch_cnt, m_cnt);
        chk("inst_exc", inst_exc, m_have && m_exc);
        if (m_have) chk("inst_out", inst_out, m_inst);
        if (inst_valid) chk("no_stale_deliver", inst_out == 32'hDEADBEEF, 0);
    end

    // memory responder and next-PC source
    bit pend = 0, force_en = 0, npc_auto = 1;
    logic [31:0] pend_d, force_d = 32'h0, npc_fixed = 32'h0;
    int wait_n = 0, mem_lat = 0;
    logic [31:0] issued[$];

    task automatic cyc();
        bit acc;
        logic [31:0] a;
        acc = imem_req_valid && imem_req_ready;
        a = imem_req_addr;
        @(posedge clk);
        model_update();
        if (acc && rstn) begin
            issued.push_back(a);
            pend = 1; wait_n = mem_lat;
            pend_d = force_en ? force_d : a ^ 32'hA5A5_0000;
        end
        @(negedge clk);
        #1;
        imem_rsp_valid = 0;
        if (pend) begin
            if (wait_n == 0) begin imem_rsp_valid = 1; imem_rsp_data = pend_d; pend = 0; end
            else wait_n--;
        end
        npc_in = npc_auto ? pc_out + 32'd4 : npc_fixed;
    endtask

    initial begin
        int c, n;
        logic [31:0] a, p0, i0, c0;
        model_reset();
        #1 rstn = 0;
        repeat (2) cyc();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_cnt", fetch_cnt, 32'h0);
        chk("rst_valid", {imem_req_valid, inst_valid, inst_exc}, 3'b000);
        rstn = 1;

        // zero-wait streaming
        c = 0;
        while (c < 10 && !inst_valid) begin cyc(); c++; end
        chk("first_valid_cycle", c, 3);
        for (int k = 0; k < 30 && fetch_cnt != 3; k++) cyc();
        chk("cnt_three", fetch_cnt, 32'd3);
        chk("issued_n", issued.size() >= 3, 1);
        chk("addr0", issued[0], 32'h0);
        chk("addr1", issued[1], 32'h4);
        chk("addr2", issued[2], 32'h8);

        // decode stall
        inst_ready = 0;
        for (int k = 0; k < 10 && !inst_valid; k++) cyc();
        p0 = pc_out; i0 = inst_out; c0 = fetch_cnt; n = issued.size();
        repeat (5) cyc();
        chk("stall_valid", inst_valid, 1);
        chk("stall_pc", pc_out, p0);
        chk("stall_inst", inst_out, i0);
        chk("stall_cnt", fetch_cnt, c0);
        chk("stall_noreq", issued.size(), n);
        inst_ready = 1;

        // memory backpressure
        imem_req_ready = 0;
        for (int k = 0; k < 10 && !imem_req_valid; k++) cyc();
        a = imem_req_addr; n = issued.size();
        repeat (4) cyc();
        chk("bp_addr", imem_req_addr, a);
        chk("bp_none", issued.size(), n);
        imem_req_ready = 1;
        cyc();
        cyc();
        chk("bp_one", issued.size(), n + 1);
        chk("bp_which", issued[n], a);

        // redirect while waiting on a slow response
        for (int k = 0; k < 10 && !imem_req_valid; k++) cyc();
        mem_lat = 3; force_en = 1; force_d = 32'hDEADBEEF;
        cyc();
        force_en = 0; mem_lat = 0;
        c0 = fetch_cnt; n = issued.size();
        chk("in_wait", m_out && !m_stale && !imem_req_valid, 1);
        redirect_valid = 1; redirect_pc = 32'h100;
        cyc();
        redirect_valid = 0;
        for (int k = 0; k < 20 && issued.size() == n; k++) cyc();
        chk("redir_req", issued.size(), n + 1);
        chk("redir_addr", issued[n], 32'h100);
        chk("redir_cnt", fetch_cnt, c0);

        // redirect in OUT overrides a simultaneous accept
        inst_ready = 0;
        for (int k = 0; k < 10 && !inst_valid; k++) cyc();
        c0 = fetch_cnt;
        npc_auto = 0; npc_fixed = 32'h999C;
        inst_ready = 1; redirect_valid = 1; redirect_pc = 32'h200;
        cyc();
        redirect_valid = 0; npc_auto = 1;
        chk("out_redir_pc", pc_out, 32'h200);
        chk("out_redir_cnt", fetch_cnt, c0);
        chk("out_redir_drop", inst_valid, 0);

        // reset mid-transaction
        mem_lat = 2;
        for (int k = 0; k < 10 && !imem_req_valid; k++) cyc();
        cyc();
        rstn = 0; model_reset(); pend = 0; imem_rsp_valid = 0; mem_lat = 0;
        cyc();
        chk("mid_rst_pc", pc_out, 32'h0);
        chk("mid_rst_cnt", fetch_cnt, 32'h0);
        rstn = 1;
        n = issued.size();
        for (int k = 0; k < 10 && issued.size() == n; k++) cyc();
        chk("post_rst_addr", issued.size() > n ? issued[n] : 32'hFFFF_FFFF, 32'h0);

`ifdef IFU_MISALIGN_CHK_EN
        npc_auto = 0; npc_fixed = 32'h102;
        for (int k = 0; k < 20 && pc_out != 32'h102; k++) cyc();
        npc_auto = 1; inst_ready = 0; n = issued.size();
        for (int k = 0; k < 10 && !inst_valid; k++) cyc();
        chk("mis_valid", inst_valid, 1);
        chk("mis_exc", inst_exc, 1);
        chk("mis_nop", inst_out, 32'h13);
        chk("mis_noreq", issued.size(), n);
        redirect_valid = 1; redirect_pc = 32'h200;
        cyc();
        redirect_valid = 0; inst_ready = 1;
        for (int k = 0; k < 10 && issued.size() == n; k++) cyc();
        chk("mis_recover", issued.size() > n ? issued[n] : 32'hFFFF_FFFF, 32'h200);
`endif
        repeat (6) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
